eth_phy_10g_link_ctrl: RTL and testbench

ETH_PHY_10G_LINK_CTRL -- requirements
Module: eth_phy_10g_link_ctrl

---
 rtl/eth_phy_10g_link_pkg.sv | 36 +++
 rtl/eth_phy_10g_link_ctrl_if.sv | 29 ++
 rtl/eth_phy_10g_link_timer.sv | 45 ++++
 rtl/eth_phy_10g_link_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_phy_10g_link_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_phy_10g_link_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_phy_10g_link_pkg
// Brief   : Shared state encodings, field widths and parameter defaults for
//           the 10G PHY link bring-up controller.
// Revision: 1.0 - initial release
// ============================================================================
package eth_phy_10g_link_pkg;

  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT  = 4096;
  localparam int DEF_STABLE_CYCLES = 125;
  localparam int DEF_MAX_RETRIES   = 15;

  localparam int ERR_CNT_W = 7;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_RST         = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STABLE = 3'd3,
    ST_UP          = 3'd4,
    ST_FAULT       = 3'd5,
    ST_PRBS        = 3'd6
  } link_state_e;

  // Largest of three cycle counts; sizes the shared state timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_phy_10g_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : eth_phy_10g_link_ctrl_if
// Brief   : PHY-side status/control bundle between the link controller
//           (master) and the PCS/SerDes block (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface eth_phy_10g_link_ctrl_if;
  import eth_phy_10g_link_pkg::*;

  logic                 rx_block_lock;
  logic                 rx_high_ber;
  logic [ERR_CNT_W-1:0] rx_error_count;
  logic                 serdes_rx_reset_req;
  logic                 cfg_tx_prbs31_enable;
  logic                 cfg_rx_prbs31_enable;

  modport master (
    input  rx_block_lock, rx_high_ber, rx_error_count,
    output serdes_rx_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable
  );

  modport slave (
    output rx_block_lock, rx_high_ber, rx_error_count,
    input  serdes_rx_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable
  );

endinterface
`default_nettype wire

// File: rtl/eth_phy_10g_link_timer.sv
`default_nettype none
// ============================================================================
// Module  : eth_phy_10g_link_timer
// Brief   : Loadable, clearable up-counter that saturates instead of
//           wrapping, with a terminal-count flag against a supplied value.
// Revision: 1.0 - initial release
// ============================================================================
module eth_phy_10g_link_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_tc
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear wins over load, load wins over increment; hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign o_tc = (count_q == i_term);

endmodule
`default_nettype wire

// File: rtl/eth_phy_10g_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : eth_phy_10g_link_ctrl
// Brief   : 10GBASE-R receive link bring-up controller. Pulses the SerDes RX
//           reset, waits for block lock, qualifies a stable clean period,
//           tracks retries/drops, and runs a PRBS31 error-accumulation mode.
// Revision: 1.0 - initial release
// ============================================================================
module eth_phy_10g_link_ctrl
  import eth_phy_10g_link_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                       rx_clk,
  input  logic                       rx_rst_n,
  eth_phy_10g_link_ctrl_if.master    phy,
  input  logic                       cfg_enable,
  input  logic                       cfg_prbs_req,
  output logic                       link_up,
  output logic                       link_fault,
  output logic [STATE_W-1:0]         link_state,
  output logic [7:0]                 retry_count,
  output logic [7:0]                 link_drop_count,
  output logic [15:0]                prbs_err_accum
);

  localparam int TMR_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);

  link_state_e state_d,      state_q;
  logic        serdes_rst_d, serdes_rst_q;
  logic        prbs_en_d,    prbs_en_q;
  logic        link_up_d,    link_up_q;
  logic        fault_d,      fault_q;
  logic [7:0]  retry_d,      retry_q;
  logic [7:0]  drop_d,       drop_q;
  logic [15:0] accum_d,      accum_q;

  logic             timer_clr;
  logic             timer_inc;
  logic [TMR_W-1:0] timer_term;
  logic             timer_tc;
  logic [16:0]      accum_sum;

  // One timer is shared by every timed state; its terminal value follows the state.
  always_comb begin
    case (state_q)
      ST_RST:       timer_term = TMR_W'(RESET_CYCLES - 1);
      ST_WAIT_LOCK: timer_term = TMR_W'(LOCK_TIMEOUT - 1);
      default:      timer_term = TMR_W'(STABLE_CYCLES - 1);
    endcase
  end

  eth_phy_10g_link_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (rx_clk),
    .rst_n      (rx_rst_n),
    .i_clr      (timer_clr),
    .i_load     (1'b0),
    .i_load_val ({TMR_W{1'b0}}),
    .i_inc      (timer_inc),
    .i_term     (timer_term),
    .o_tc       (timer_tc)
  );

  assign accum_sum = {1'b0, accum_q} + 17'(phy.rx_error_count);

  // Next-state and registered-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    serdes_rst_d = serdes_rst_q;
    prbs_en_d    = prbs_en_q;
    link_up_d    = link_up_q;
    fault_d      = fault_q;
    retry_d      = retry_q;
    drop_d       = drop_q;
    accum_d      = accum_q;
    timer_clr    = 1'b0;
    timer_inc    = 1'b0;

    // Dropping the enable aborts any bring-up activity; PRBS mode ignores it.
    if (!cfg_enable && (state_q != ST_PRBS) && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      timer_clr    = 1'b1;
      retry_d      = 8'd0;
      link_up_d    = 1'b0;
      fault_d      = 1'b0;
      serdes_rst_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_clr = 1'b1;
          if (cfg_prbs_req) begin
            state_d   = ST_PRBS;
            prbs_en_d = 1'b1;
            accum_d   = 16'd0;
          end else if (cfg_enable) begin
            state_d      = ST_RST;
            serdes_rst_d = 1'b1;
          end
        end

        ST_RST: begin
          if (timer_tc) begin
            state_d      = ST_WAIT_LOCK;
            serdes_rst_d = 1'b0;
            timer_clr    = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is checked first so it wins a tie with the timeout.
          if (phy.rx_block_lock) begin
            state_d   = ST_WAIT_STABLE;
            timer_clr = 1'b1;
          end else if (timer_tc) begin
            retry_d   = retry_q + 8'd1;
            timer_clr = 1'b1;
            if (retry_d == 8'(MAX_RETRIES)) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d      = ST_RST;
              serdes_rst_d = 1'b1;
            end
          end else begin
            timer_inc = 1'b1;
          end
        end

        ST_WAIT_STABLE: begin
          if (phy.rx_block_lock && !phy.rx_high_ber) begin
            if (timer_tc) begin
              state_d   = ST_UP;
              link_up_d = 1'b1;
              retry_d   = 8'd0;
              timer_clr = 1'b1;
            end else begin
              timer_inc = 1'b1;
            end
          end else begin
            state_d   = ST_WAIT_LOCK;
            timer_clr = 1'b1;
          end
        end

        ST_UP: begin
          if (!phy.rx_block_lock || phy.rx_high_ber) begin
            state_d      = ST_RST;
            link_up_d    = 1'b0;
            serdes_rst_d = 1'b1;
            timer_clr    = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
        end

        ST_FAULT: begin
          timer_clr = 1'b1;
        end

        ST_PRBS: begin
          timer_clr = 1'b1;
          if (!cfg_prbs_req) begin
            state_d   = ST_IDLE;
            prbs_en_d = 1'b0;
          end else begin
            accum_d = accum_sum[16] ? 16'hFFFF : accum_sum[15:0];
          end
        end

        default: begin
          state_d      = ST_IDLE;
          serdes_rst_d = 1'b0;
          prbs_en_d    = 1'b0;
          link_up_d    = 1'b0;
          fault_d      = 1'b0;
          timer_clr    = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything including the drop counter.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q      <= ST_IDLE;
      serdes_rst_q <= 1'b0;
      prbs_en_q    <= 1'b0;
      link_up_q    <= 1'b0;
      fault_q      <= 1'b0;
      retry_q      <= 8'd0;
      drop_q       <= 8'd0;
      accum_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      serdes_rst_q <= serdes_rst_d;
      prbs_en_q    <= prbs_en_d;
      link_up_q    <= link_up_d;
      fault_q      <= fault_d;
      retry_q      <= retry_d;
      drop_q       <= drop_d;
      accum_q      <= accum_d;
    end
  end

  assign phy.serdes_rx_reset_req  = serdes_rst_q;
  assign phy.cfg_tx_prbs31_enable = prbs_en_q;
  assign phy.cfg_rx_prbs31_enable = prbs_en_q;
  assign link_up                  = link_up_q;
  assign link_fault               = fault_q;
  assign link_state               = state_q;
  assign retry_count              = retry_q;
  assign link_drop_count          = drop_q;
  assign prbs_err_accum           = accum_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_phy_10g_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_phy_10g_link_ctrl
// Brief   : Directed self-checking bench for eth_phy_10g_link_ctrl with
//           RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_phy_10g_link_ctrl;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n;
  logic        cfg_enable;
  logic        cfg_prbs_req;
  logic        link_up;
  logic        link_fault;
  logic [2:0]  link_state;
  logic [7:0]  retry_count;
  logic [7:0]  link_drop_count;
  logic [15:0] prbs_err_accum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_link_ctrl_if phy_if ();

  eth_phy_10g_link_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3)
  ) dut (
    .rx_clk          (rx_clk),
    .rx_rst_n        (rx_rst_n),
    .phy             (phy_if.master),
    .cfg_enable      (cfg_enable),
    .cfg_prbs_req    (cfg_prbs_req),
    .link_up         (link_up),
    .link_fault      (link_fault),
    .link_state      (link_state),
    .retry_count     (retry_count),
    .link_drop_count (link_drop_count),
    .prbs_err_accum  (prbs_err_accum)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge rx_clk);
      @(negedge rx_clk);
    end
  endtask

  initial begin
    int hi_cnt;
    int rises;
    int ncyc;
    logic prev;

    rx_rst_n                    = 1'b1;
    cfg_enable                  = 1'b0;
    cfg_prbs_req                = 1'b0;
    phy_if.rx_block_lock        = 1'b0;
    phy_if.rx_high_ber          = 1'b0;
    phy_if.rx_error_count       = 7'd0;
    #1 rx_rst_n = 1'b0;
    @(negedge rx_clk);
    @(negedge rx_clk);

    check_val("rst_state",  int'(link_state), 0);
    check_val("rst_serdes", int'(phy_if.serdes_rx_reset_req), 0);
    check_val("rst_linkup", int'(link_up), 0);
    check_val("rst_accum",  int'(prbs_err_accum), 0);
    rx_rst_n = 1'b1;
    tick(2);
    check_val("idle_hold", int'(link_state), 0);

    // Clean bring-up: 4-cycle reset pulse, lock 10 cycles into WAIT_LOCK, 8 stable cycles.
    cfg_enable = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (phy_if.serdes_rx_reset_req) hi_cnt++;
    end
    check_val("a_rst_pulse_len", hi_cnt, 4);
    check_val("a_wait_lock", int'(link_state), 2);
    tick(10);
    check_val("a_still_wait_lock", int'(link_state), 2);
    phy_if.rx_block_lock = 1'b1;
    tick();
    check_val("a_wait_stable", int'(link_state), 3);
    tick(7);
    check_val("a_not_up_yet", int'(link_up), 0);
    tick();
    check_val("a_state_up", int'(link_state), 4);
    check_val("a_link_up", int'(link_up), 1);
    check_val("a_retry", int'(retry_count), 0);

    // One-cycle high BER while up: count a drop and restart with a fresh reset pulse.
    phy_if.rx_high_ber = 1'b1;
    tick();
    phy_if.rx_high_ber = 1'b0;
    check_val("b_state_rst", int'(link_state), 1);
    check_val("b_drop_cnt", int'(link_drop_count), 1);
    check_val("b_link_down", int'(link_up), 0);
    hi_cnt = phy_if.serdes_rx_reset_req ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (phy_if.serdes_rx_reset_req) hi_cnt++;
    end
    check_val("b_rst_pulse_len", hi_cnt, 4);
    check_val("b_wait_stable", int'(link_state), 3);

    // Lock lost part-way through the stable window.
    tick(4);
    check_val("c_still_stable", int'(link_state), 3);
    phy_if.rx_block_lock = 1'b0;
    tick();
    check_val("c_back_wait_lock", int'(link_state), 2);
    check_val("c_retry_same", int'(retry_count), 0);
    check_val("c_link_up_low", int'(link_up), 0);

    // Disable returns to IDLE but the drop counter survives.
    cfg_enable = 1'b0;
    tick();
    check_val("d_idle", int'(link_state), 0);
    check_val("d_drop_kept", int'(link_drop_count), 1);

    // Lock never appears: three reset attempts then FAULT on cycle 109.
    cfg_enable = 1'b1;
    prev  = 1'b0;
    rises = 0;
    ncyc  = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      ncyc++;
      if (phy_if.serdes_rx_reset_req && !prev) rises++;
      prev = phy_if.serdes_rx_reset_req;
      if (link_state == 3'd5) break;
    end
    check_val("e_fault_cycle", ncyc, 109);
    check_val("e_rst_pulses", rises, 3);
    check_val("e_retry", int'(retry_count), 3);
    check_val("e_fault", int'(link_fault), 1);
    check_val("e_state_fault", int'(link_state), 5);
    tick(5);
    check_val("e_fault_held", int'(link_state), 5);
    cfg_enable = 1'b0;
    tick();
    check_val("e_idle", int'(link_state), 0);
    check_val("e_fault_clr", int'(link_fault), 0);
    check_val("e_retry_clr", int'(retry_count), 0);

    // Lock arriving on the final timeout cycle wins over the retry.
    cfg_enable = 1'b1;
    tick(5);
    tick(31);
    check_val("f_last_wait_cycle", int'(link_state), 2);
    check_val("f_no_retry_yet", int'(retry_count), 0);
    phy_if.rx_block_lock = 1'b1;
    tick();
    check_val("f_lock_wins", int'(link_state), 3);
    check_val("f_retry_zero", int'(retry_count), 0);
    cfg_enable = 1'b0;
    tick();

    // PRBS mode: accumulate, saturate, exit, and clear on re-entry.
    cfg_enable            = 1'b1;
    cfg_prbs_req          = 1'b1;
    phy_if.rx_error_count = 7'd3;
    tick();
    check_val("g_state_prbs", int'(link_state), 6);
    check_val("g_tx_prbs", int'(phy_if.cfg_tx_prbs31_enable), 1);
    check_val("g_rx_prbs", int'(phy_if.cfg_rx_prbs31_enable), 1);
    check_val("g_accum_entry", int'(prbs_err_accum), 0);
    tick(10);
    check_val("g_accum_30", int'(prbs_err_accum), 30);
    phy_if.rx_error_count = 7'd127;
    tick(515);
    check_val("g_accum_pre_sat", int'(prbs_err_accum), 65435);
    tick();
    check_val("g_accum_sat", int'(prbs_err_accum), 65535);
    tick(5);
    check_val("g_accum_sat_hold", int'(prbs_err_accum), 65535);
    cfg_enable   = 1'b0;
    cfg_prbs_req = 1'b0;
    tick();
    check_val("g_exit_idle", int'(link_state), 0);
    check_val("g_tx_prbs_off", int'(phy_if.cfg_tx_prbs31_enable), 0);
    check_val("g_rx_prbs_off", int'(phy_if.cfg_rx_prbs31_enable), 0);
    cfg_enable   = 1'b1;
    cfg_prbs_req = 1'b1;
    tick();
    check_val("g_reentry_clear", int'(prbs_err_accum), 0);
    cfg_prbs_req          = 1'b0;
    phy_if.rx_error_count = 7'd0;
    phy_if.rx_block_lock  = 1'b0;
    tick();
    check_val("g_back_idle", int'(link_state), 0);

    // Asynchronous reset in the middle of the reset pulse.
    tick(2);
    check_val("h_in_rst", int'(phy_if.serdes_rx_reset_req), 1);
    #2 rx_rst_n = 1'b0;
    #1;
    check_val("h_async_serdes", int'(phy_if.serdes_rx_reset_req), 0);
    check_val("h_async_state", int'(link_state), 0);
    check_val("h_async_drop", int'(link_drop_count), 0);
    #1 rx_rst_n = 1'b1;
    tick();
    check_val("h_restart", int'(link_state), 1);

    // Asynchronous reset while waiting for lock, then bring-up restarts.
    tick(4);
    check_val("i_wait_lock", int'(link_state), 2);
    tick(3);
    #2 rx_rst_n = 1'b0;
    #1;
    check_val("i_async_state", int'(link_state), 0);
    check_val("i_async_retry", int'(retry_count), 0);
    check_val("i_async_serdes", int'(phy_if.serdes_rx_reset_req), 0);
    #1 rx_rst_n = 1'b1;
    tick();
    check_val("i_restart", int'(link_state), 1);
    check_val("i_restart_serdes", int'(phy_if.serdes_rx_reset_req), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
